// File: rtl/riscv_retire_trace_buffer.sv
// Retire trace buffer: captures one record per retired instruction
// into a circular FIFO and drains it through a valid/ready port.
module riscv_retire_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16,
    parameter int SEQ_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       update_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            instr_i,
    input  logic [4:0]                 reg_addr_i,
    input  logic [XLEN-1:0]            reg_data_i,
    input  logic [XLEN-1:0]            mem_addr_i,
    input  logic [XLEN-1:0]            mem_data_i,
    input  logic                       mem_wrt_i,
    input  logic                       mem_read_i,
    input  logic                       clear_i,
    output logic                       rec_valid_o,
    input  logic                       rec_ready_i,
    output logic [SEQ_W-1:0]           rec_seq_o,
    output logic [XLEN-1:0]            rec_pc_o,
    output logic [XLEN-1:0]            rec_instr_o,
    output logic [5+XLEN-1:0]          rec_reg_o,
    output logic [2+2*XLEN-1:0]        rec_mem_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [CNT_W-1:0]           overflow_cnt_o,
    output logic                       halted_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    PTR_ONE = PW'(1);
    localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic [SEQ_W-1:0]    seq;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     instr;
        logic [5+XLEN-1:0]   regs;
        logic [2+2*XLEN-1:0] mem;
    } rec_t;

    rec_t             store [DEPTH];
    rec_t             head;
    rec_t             rec_in;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [SEQ_W-1:0] seq;
    logic [CNT_W-1:0] ovf;
    logic             halted;
    logic             empty;
    logic             full;
    logic             ret;
    logic             pop;
    logic             push;
    logic             drop;

    // Handshake and capture qualifiers; a pop frees the slot a full push reuses.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        ret   = update_i && !halted && !clear_i;
        pop   = !empty && rec_ready_i && !clear_i;
        push  = ret && (!full || pop);
        drop  = ret && !push;
        rec_in.seq   = seq;
        rec_in.pc    = pc_i;
        rec_in.instr = instr_i;
        rec_in.regs  = {reg_addr_i, reg_data_i};
        rec_in.mem   = {mem_wrt_i, mem_read_i, mem_addr_i, mem_data_i};
    end

    // Control state: pointers, sequence, overflow and halt tracking.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            seq    <= '0;
            ovf    <= '0;
            halted <= 1'b0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            seq    <= '0;
            ovf    <= '0;
            halted <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (ret) begin
                seq <= seq + SEQ_ONE;
                if (instr_i == '0)
                    halted <= 1'b1;
            end
            if (drop && ovf != '1)
                ovf <= ovf + CNT_ONE;
        end
    end

    // Record storage; contents are not reset, only the pointers are.
    always_ff @(posedge clk_i) begin
        if (push)
            store[wr_ptr[AW-1:0]] <= rec_in;
    end

    // Show-ahead head outputs, forced to zero while empty.
    always_comb begin
        head           = empty ? '0 : store[rd_ptr[AW-1:0]];
        rec_valid_o    = !empty;
        rec_seq_o      = head.seq;
        rec_pc_o       = head.pc;
        rec_instr_o    = head.instr;
        rec_reg_o      = head.regs;
        rec_mem_o      = head.mem;
        count_o        = wr_ptr - rd_ptr;
        overflow_cnt_o = ovf;
        halted_o       = halted;
    end

endmodule
